// File: rtl/text_console_buffer.sv
// Character-cell store for the VGA text console: a cursor-driven writer with
// backspace/newline handling, scroll or wrap at end of screen, and two registered read ports.
module text_console_buffer #(
  parameter int         COLS      = 12,
  parameter int         ROWS      = 9,
  parameter int         SCROLL_EN = 1,
  parameter logic [7:0] BLANK     = 8'h20,
  parameter int         IDX_W     = $clog2(COLS*ROWS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [7:0]                in_char,
  output logic                      in_ready,
  input  logic                      clear,
  output logic                      busy,
  input  logic [IDX_W-1:0]          disp_addr,
  output logic [7:0]                disp_char,
  input  logic [IDX_W-1:0]          rd_addr,
  output logic [7:0]                rd_char,
  output logic [IDX_W-1:0]          cursor_idx,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic                      wr_strobe,
  output logic [IDX_W-1:0]          wr_idx,
  output logic [7:0]                wr_char
);

  localparam int N  = COLS * ROWS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [IDX_W-1:0] LAST_I    = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] BODY_I    = IDX_W'(N - COLS);
  localparam logic [IDX_W-1:0] COLS_I    = IDX_W'(COLS);
  localparam logic [IDX_W-1:0] LASTROW_I = IDX_W'((ROWS - 1) * COLS);
  localparam logic [IDX_W-1:0] ONE_I     = IDX_W'(1);
  localparam logic [CW-1:0]    LAST_C    = CW'(COLS - 1);
  localparam logic [CW-1:0]    ONE_C     = CW'(1);
  localparam logic [RW-1:0]    LAST_R    = RW'(ROWS - 1);
  localparam logic [RW-1:0]    ONE_R     = RW'(1);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SCROLL} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [RW-1:0]     cur_row_q, cur_row_d;
  logic [CW-1:0]     cur_col_q, cur_col_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [7:0]        wr_char_q, wr_char_d;
  logic [7:0]        disp_char_q, rd_char_q;

  logic [7:0]        mem_q [N];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [7:0]        mem_wdata;
  logic [IDX_W-1:0]  scroll_src;
  logic              eos;
  logic              is_print, is_bs, is_nl;

  assign busy       = (state_q != ST_IDLE);
  assign in_ready   = !busy && !clear;
  assign disp_char  = disp_char_q;
  assign rd_char    = rd_char_q;
  assign cursor_idx = cur_idx_q;
  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_idx     = wr_idx_q;
  assign wr_char    = wr_char_q;

  assign is_print   = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign is_bs      = (in_char == 8'h08);
  assign is_nl      = (in_char == 8'h0A) || (in_char == 8'h0D);
  // Source stays in range even on the blank-fill tail of a scroll.
  assign scroll_src = (cnt_q < BODY_I) ? (cnt_q + COLS_I) : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_idx_d   = cur_idx_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    wr_strobe_d = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_char_d   = wr_char_q;
    mem_we      = 1'b0;
    mem_waddr   = cnt_q;
    mem_wdata   = BLANK;
    eos         = 1'b0;

    if (clear) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          mem_we = 1'b1;
          if (cnt_q == LAST_I) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            cur_idx_d = '0;
            cur_row_d = '0;
            cur_col_d = '0;
          end else begin
            cnt_d = cnt_q + ONE_I;
          end
        end
        ST_SCROLL: begin
          mem_we    = 1'b1;
          mem_wdata = (cnt_q < BODY_I) ? mem_q[scroll_src] : BLANK;
          if (cnt_q == LAST_I) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            cur_idx_d = LASTROW_I;
            cur_row_d = LAST_R;
            cur_col_d = '0;
          end else begin
            cnt_d = cnt_q + ONE_I;
          end
        end
        ST_IDLE: begin
          if (in_valid) begin
            if (is_print) begin
              mem_we      = 1'b1;
              mem_waddr   = cur_idx_q;
              mem_wdata   = in_char;
              wr_strobe_d = 1'b1;
              wr_idx_d    = cur_idx_q;
              wr_char_d   = in_char;
              if (cur_idx_q == LAST_I) begin
                eos = 1'b1;
              end else if (cur_col_q == LAST_C) begin
                cur_col_d = '0;
                cur_row_d = cur_row_q + ONE_R;
                cur_idx_d = cur_idx_q + ONE_I;
              end else begin
                cur_col_d = cur_col_q + ONE_C;
                cur_idx_d = cur_idx_q + ONE_I;
              end
            end else if (is_bs) begin
              if (cur_idx_q != '0) begin
                mem_we    = 1'b1;
                mem_waddr = cur_idx_q - ONE_I;
                cur_idx_d = cur_idx_q - ONE_I;
                if (cur_col_q == '0) begin
                  cur_col_d = LAST_C;
                  cur_row_d = cur_row_q - ONE_R;
                end else begin
                  cur_col_d = cur_col_q - ONE_C;
                end
              end
            end else if (is_nl) begin
              if (cur_row_q == LAST_R) begin
                eos = 1'b1;
              end else begin
                cur_row_d = cur_row_q + ONE_R;
                cur_col_d = '0;
                cur_idx_d = cur_idx_q + (COLS_I - IDX_W'(cur_col_q));
              end
            end
          end
        end
        default: begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      endcase
    end

    // Scroll parks the cursor on the last row when it finishes; wrap jumps home now.
    if (eos) begin
      if (SCROLL_EN != 0) begin
        state_d = ST_SCROLL;
        cnt_d   = '0;
      end else begin
        cur_idx_d = '0;
        cur_row_d = '0;
        cur_col_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      cur_idx_q   <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= '0;
      wr_char_q   <= '0;
      disp_char_q <= '0;
      rd_char_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_idx_q   <= cur_idx_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      wr_strobe_q <= wr_strobe_d;
      wr_idx_q    <= wr_idx_d;
      wr_char_q   <= wr_char_d;
      disp_char_q <= (disp_addr <= LAST_I) ? mem_q[disp_addr] : BLANK;
      rd_char_q   <= (rd_addr <= LAST_I) ? mem_q[rd_addr] : BLANK;
    end
  end

  // Cell array carries no reset; a CLEAR pass always follows reset release.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_text_console_buffer.sv
// Scoreboard bench for text_console_buffer: one scrolling and one wrapping instance share stimulus.
module tb_text_console_buffer;
  localparam int N = 108;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       va = 1'b0, vb = 1'b0, clear = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic [6:0] disp_addr = '0, rd_addr = '0;

  logic       rdy_a, busy_a, ws_a, rdy_b, busy_b, ws_b;
  logic [7:0] disp_a, rd_a, wc_a, disp_b, rd_b, wc_b;
  logic [6:0] cidx_a, wi_a, cidx_b, wi_b;
  logic [3:0] crow_a, ccol_a, crow_b, ccol_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  text_console_buffer #(.COLS(12), .ROWS(9), .SCROLL_EN(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(va), .in_char(in_char), .in_ready(rdy_a),
    .clear(clear), .busy(busy_a), .disp_addr(disp_addr), .disp_char(disp_a),
    .rd_addr(rd_addr), .rd_char(rd_a), .cursor_idx(cidx_a), .cursor_row(crow_a),
    .cursor_col(ccol_a), .wr_strobe(ws_a), .wr_idx(wi_a), .wr_char(wc_a));

  text_console_buffer #(.COLS(12), .ROWS(9), .SCROLL_EN(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in_char(in_char), .in_ready(rdy_b),
    .clear(clear), .busy(busy_b), .disp_addr(disp_addr), .disp_char(disp_b),
    .rd_addr(rd_addr), .rd_char(rd_b), .cursor_idx(cidx_b), .cursor_row(crow_b),
    .cursor_col(ccol_b), .wr_strobe(ws_b), .wr_idx(wi_b), .wr_char(wc_b));

  typedef struct {logic [6:0] idx; logic [7:0] ch;} wr_t;
  typedef struct {int addr; logic [7:0] ea; logic chk_b; logic [7:0] eb;} rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  wr_t wr_e;
  rd_t rd_e;
  logic rd_req = 1'b0;
  logic rd_req_q = 1'b0;
  logic [7:0] exp_a [N];
  logic [7:0] exp_b [N];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endfunction

  always @(posedge clk) rd_req_q <= rd_req;

  // Monitor: pops expected write events and read results as the DUT presents them.
  always @(negedge clk) begin
    if (ws_a) begin
      if (wr_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected: got idx %0d char %0h, expected no strobe", wi_a, wc_a);
      end else begin
        wr_e = wr_q.pop_front();
        check("wr_idx", 32'(wi_a), 32'(wr_e.idx));
        check("wr_char", 32'(wc_a), 32'(wr_e.ch));
      end
    end
    if (rd_req_q && rd_q.size() != 0) begin
      rd_e = rd_q.pop_front();
      check($sformatf("rd_char_a[%0d]", rd_e.addr), 32'(rd_a), 32'(rd_e.ea));
      check($sformatf("disp_char_a[%0d]", rd_e.addr), 32'(disp_a), 32'(rd_e.ea));
      if (rd_e.chk_b) check($sformatf("rd_char_b[%0d]", rd_e.addr), 32'(rd_b), 32'(rd_e.eb));
    end
  end

  task automatic rd(input int a, input logic [7:0] ea, input logic chkb, input logic [7:0] eb);
    rd_addr   = 7'(a);
    disp_addr = 7'(a);
    rd_req    = 1'b1;
    rd_q.push_back('{a, ea, chkb, eb});
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic read_all(input logic chkb);
    for (int i = 0; i < N; i++) rd(i, exp_a[i], chkb, exp_b[i]);
    drain();
  endtask

  task automatic set_all(input logic [7:0] c);
    for (int i = 0; i < N; i++) begin
      exp_a[i] = c;
      exp_b[i] = c;
    end
  endtask

  // widx < 0 means no write strobe is expected for this character.
  task automatic send(input logic [7:0] c, input logic both, input int widx);
    int n;
    n = 0;
    va = 1'b1;
    vb = both;
    in_char = c;
    while (!rdy_a && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("send_ready_timeout", 32'(n), 32'(0));
    if (widx >= 0) wr_q.push_back('{7'(widx), c});
    @(posedge clk); #1;
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int exp_n);
    int n;
    n = 0;
    while (busy_a && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_busy_cycles"}, 32'(n), 32'(exp_n));
    check({nm, "_in_ready"}, 32'(rdy_a), 32'(1));
  endtask

  task automatic check_reset_state();
    check("rst_busy", 32'(busy_a), 32'(1));
    check("rst_in_ready", 32'(rdy_a), 32'(0));
    check("rst_cursor_idx", 32'(cidx_a), 32'(0));
    check("rst_cursor_row", 32'(crow_a), 32'(0));
    check("rst_cursor_col", 32'(ccol_a), 32'(0));
    check("rst_rd_char", 32'(rd_a), 32'(0));
    check("rst_disp_char", 32'(disp_a), 32'(0));
    check("rst_wr_strobe", 32'(ws_a), 32'(0));
    check("rst_wr_idx", 32'(wi_a), 32'(0));
    check("rst_wr_char", 32'(wc_a), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b1;
    wait_idle("boot", 108);
    set_all(8'h20);
    check("boot_cursor", 32'(cidx_a), 32'(0));
    read_all(1'b1);
    rd(120, 8'h20, 1'b1, 8'h20);
    drain();

    send("A", 1'b1, 0);
    send("B", 1'b1, 1);
    send(8'h08, 1'b1, -1);
    send("C", 1'b1, 1);
    exp_a[0] = 8'h41; exp_a[1] = 8'h43;
    exp_b[0] = 8'h41; exp_b[1] = 8'h43;
    check("abc_cursor_idx", 32'(cidx_a), 32'(2));
    check("abc_cursor_idx_b", 32'(cidx_b), 32'(2));
    for (int i = 0; i < 3; i++) rd(i, exp_a[i], 1'b1, exp_b[i]);
    drain();

    send(8'h08, 1'b1, -1);
    send(8'h08, 1'b1, -1);
    send(8'h08, 1'b1, -1);
    check("bs_at_zero_cursor", 32'(cidx_a), 32'(0));
    send("X", 1'b1, 0);
    send(8'h0D, 1'b1, -1);
    exp_a[0] = 8'h58; exp_a[1] = 8'h20;
    exp_b[0] = 8'h58; exp_b[1] = 8'h20;
    check("nl_cursor_row", 32'(crow_a), 32'(1));
    check("nl_cursor_col", 32'(ccol_a), 32'(0));
    check("nl_cursor_idx", 32'(cidx_a), 32'(12));
    for (int i = 0; i < 3; i++) rd(i, exp_a[i], 1'b1, exp_b[i]);
    drain();

    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    wait_idle("clear", 108);
    check("clear_cursor", 32'(cidx_a), 32'(0));
    check("clear_busy_b", 32'(busy_b), 32'(0));

    for (int i = 0; i < N; i++) send(8'h30 + 8'(i / 12), 1'b1, i);
    check("scroll_busy_rise", 32'(busy_a), 32'(1));
    check("wrap_busy_b", 32'(busy_b), 32'(0));
    check("wrap_cursor_b", 32'(cidx_b), 32'(0));
    check("wrap_ready_b", 32'(rdy_b), 32'(1));
    wait_idle("scroll", 108);
    check("scroll_cursor_idx", 32'(cidx_a), 32'(96));
    check("scroll_cursor_row", 32'(crow_a), 32'(8));
    check("scroll_cursor_col", 32'(ccol_a), 32'(0));
    for (int i = 0; i < N; i++) begin
      exp_a[i] = (i < 96) ? 8'h31 + 8'(i / 12) : 8'h20;
      exp_b[i] = 8'h30 + 8'(i / 12);
    end
    read_all(1'b1);

    send(8'h0D, 1'b0, -1);
    check("nl_scroll_busy", 32'(busy_a), 32'(1));
    repeat (39) @(posedge clk);
    #1;
    va = 1'b1;
    in_char = "Z";
    clear = 1'b1;
    #1;
    check("clear_beats_valid_ready", 32'(rdy_a), 32'(0));
    @(posedge clk); #1;
    clear = 1'b0;
    va = 1'b0;
    check("abort_busy", 32'(busy_a), 32'(1));
    wait_idle("abort_clear", 108);
    set_all(8'h20);
    check("abort_cursor", 32'(cidx_a), 32'(0));
    check("abort_cursor_b", 32'(cidx_b), 32'(0));
    read_all(1'b1);

    send("Q", 1'b0, 0);
    for (int i = 0; i < 9; i++) send(8'h0D, 1'b0, -1);
    check("reset_scroll_busy", 32'(busy_a), 32'(1));
    repeat (39) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_state();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_idle("reset_clear", 108);
    check("reset_cursor", 32'(cidx_a), 32'(0));
    read_all(1'b1);

    drain();
    check("wr_queue_empty", 32'(wr_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
